key_debounce_bank: RTL

Parametrised N-channel debouncer for the mechanical keys and slide switches of the alarm-clock front panel. Per channel: synchronises the raw pin, filters bounce with a consecutive-stable counter in both directions, and produces a clean level plus single-cycle press, release and long-press events. Sits between the board pins and the mode/set control logic, which consumes events only and never raw pins.

---
 rtl/key_debounce_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/key_debounce_bank.sv
// key_debounce_bank
//   N-channel debouncer for front-panel keys and slide switches.
//   Each channel normalises pin polarity and passes the pin through a
//   two-flop synchroniser. A consecutive-stable counter then accepts a new
//   level only after it has held for DEB_CYCLES cycles. The channel emits a
//   clean level plus one-cycle press, release and long-press pulses.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       [N_CH] raw asynchronous pin levels
//   key_level    [N_CH] debounced state, 1 = pressed
//   key_press    [N_CH] one-cycle pulse on key_level 0 -> 1
//   key_release  [N_CH] one-cycle pulse on key_level 1 -> 0
//   key_long     [N_CH] one-cycle pulse LONG_CYCLES after a press, once per press
module key_debounce_bank #(
    parameter int N_CH        = 4,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 75_000_000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] key_in,
    output logic [N_CH-1:0] key_level,
    output logic [N_CH-1:0] key_press,
    output logic [N_CH-1:0] key_release,
    output logic [N_CH-1:0] key_long
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_FIRE = LW'(LONG_CYCLES - 1);

    // Hold-time counter stops at LONG_MAX so key_long cannot retrigger
    // while the key stays down.
    function automatic logic [LW-1:0] lcnt_sat_inc(input logic [LW-1:0] v);
        return (v == LONG_MAX) ? v : v + 1'b1;
    endfunction

    logic [N_CH-1:0] p;
    logic [N_CH-1:0] s0;
    logic [N_CH-1:0] s1;

    assign p = key_in ^ {N_CH{ACTIVE_LOW}};

    // Synchroniser: raw pin -> s0 -> s1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= p;
            s1 <= s0;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [DW-1:0] dcnt;
        logic [LW-1:0] lcnt;
        logic          level_r;
        logic          press_r;
        logic          release_r;
        logic          long_r;

        // Debounce filter: s1 -> level_r and press/release pulses.
        // Any cycle in which s1 agrees with the accepted level restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dcnt      <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                if (s1[ch] == level_r) begin
                    dcnt <= '0;
                end else if (dcnt == DEB_LAST) begin
                    dcnt      <= '0;
                    level_r   <= s1[ch];
                    press_r   <= s1[ch];
                    release_r <= ~s1[ch];
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

        // Long-press timer: level_r -> long_r pulse
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lcnt   <= '0;
                long_r <= 1'b0;
            end else if (!level_r) begin
                lcnt   <= '0;
                long_r <= 1'b0;
            end else begin
                lcnt   <= lcnt_sat_inc(lcnt);
                long_r <= (lcnt == LONG_FIRE);
            end
        end

        assign key_level[ch]   = level_r;
        assign key_press[ch]   = press_r;
        assign key_release[ch] = release_r;
        assign key_long[ch]    = long_r;
    end

endmodule
